// File: rtl/spi_slave_ctrl_if.sv
// SPI pin and RAM-side signal bundle for spi_slave_ctrl.
// slave modport is the controller's view; master is the pins/RAM side.
interface spi_slave_ctrl_if #(
  parameter int DATA_W  = 8,
  parameter int FRAME_W = DATA_W + 2
);
  logic               SS_n;
  logic               MOSI;
  logic               MISO;
  logic [FRAME_W-1:0] rx_data;
  logic               rx_valid;
  logic [DATA_W-1:0]  tx_data;
  logic               tx_valid;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_slave_ctrl.sv
// SPI slave front-end: deserialises 10-bit command frames for the RAM and serialises read data on MISO.
// Optional SPI_FRAME_ERR_EN adds a frame_err pulse output for frames cut short by SS_n.
module spi_slave_ctrl #(
  parameter int DATA_W  = 8,
  parameter int FRAME_W = DATA_W + 2
) (
  input  logic              clk,
  input  logic              rst,
  spi_slave_ctrl_if.slave   bus
`ifdef SPI_FRAME_ERR_EN
  ,
  output logic              frame_err
`endif
);
  localparam int CNT_W = $clog2(FRAME_W);
  localparam int TXC_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 2);
  localparam logic [TXC_W-1:0] TX_LAST  = TXC_W'(DATA_W);

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [FRAME_W-2:0] r_shift;
  logic               r_done;
  logic               r_rd_addr_seen;
  logic [DATA_W-1:0]  r_tx_shift;
  logic [TXC_W-1:0]   r_tx_cnt;
  logic               r_tx_started;
  logic               r_miso;
  logic [FRAME_W-1:0] r_rx_data;
  logic               r_rx_valid;
`ifdef SPI_FRAME_ERR_EN
  logic               r_frame_err;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_bit_cnt      <= '0;
      r_shift        <= '0;
      r_done         <= 1'b0;
      r_rd_addr_seen <= 1'b0;
      r_tx_shift     <= '0;
      r_tx_cnt       <= '0;
      r_tx_started   <= 1'b0;
      r_miso         <= 1'b0;
      r_rx_data      <= '0;
      r_rx_valid     <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
      r_frame_err    <= 1'b0;
`endif
    end else begin
      r_rx_valid <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
      r_frame_err <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          r_bit_cnt    <= '0;
          r_done       <= 1'b0;
          r_tx_started <= 1'b0;
          r_tx_cnt     <= '0;
          r_tx_shift   <= '0;
          r_miso       <= 1'b0;
          if (!bus.SS_n) r_state <= CHK_CMD;
        end
        CHK_CMD: begin
          if (bus.SS_n) begin
            r_state <= IDLE;
`ifdef SPI_FRAME_ERR_EN
            r_frame_err <= 1'b1;
`endif
          end else begin
            r_shift <= {r_shift[FRAME_W-3:0], bus.MOSI};
            if (!bus.MOSI)          r_state <= WRITE;
            else if (r_rd_addr_seen) r_state <= READ_DATA;
            else                     r_state <= READ_ADD;
          end
        end
        default: begin
          if (!r_done) begin
            // The last bit is taken even if SS_n rises on the same edge.
            if (r_bit_cnt == LAST_BIT) begin
              r_rx_data  <= {r_shift, bus.MOSI};
              r_rx_valid <= 1'b1;
              r_done     <= 1'b1;
              if (r_state == READ_ADD)       r_rd_addr_seen <= 1'b1;
              else if (r_state == READ_DATA) r_rd_addr_seen <= 1'b0;
              if (bus.SS_n) r_state <= IDLE;
            end else if (bus.SS_n) begin
              r_state   <= IDLE;
              r_bit_cnt <= '0;
`ifdef SPI_FRAME_ERR_EN
              r_frame_err <= 1'b1;
`endif
            end else begin
              r_shift   <= {r_shift[FRAME_W-3:0], bus.MOSI};
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
          end else if (bus.SS_n) begin
            r_state      <= IDLE;
            r_bit_cnt    <= '0;
            r_tx_cnt     <= '0;
            r_tx_shift   <= '0;
            r_tx_started <= 1'b0;
            r_miso       <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
            if (r_state == READ_DATA && r_tx_cnt != TX_LAST) r_frame_err <= 1'b1;
`endif
          end else if (r_state == READ_DATA) begin
            // tx_valid is a level: only its first high after the command is honoured.
            if (!r_tx_started) begin
              if (bus.tx_valid) begin
                r_tx_started <= 1'b1;
                r_miso       <= bus.tx_data[DATA_W-1];
                r_tx_shift   <= {bus.tx_data[DATA_W-2:0], 1'b0};
                r_tx_cnt     <= TXC_W'(1);
              end
            end else if (r_tx_cnt != TX_LAST) begin
              r_miso     <= r_tx_shift[DATA_W-1];
              r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
              r_tx_cnt   <= r_tx_cnt + TXC_W'(1);
            end else begin
              r_miso <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign bus.MISO     = r_miso;
  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;
`ifdef SPI_FRAME_ERR_EN
  assign frame_err    = r_frame_err;
`endif
endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Scoreboard bench for spi_slave_ctrl: directed frames then random frames with aborts,
// a RAM responder, and a negedge monitor checking rx_data words and MISO read bytes.
module tb_spi_slave_ctrl;
  localparam int DATA_W  = 8;
  localparam int FRAME_W = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;

  spi_slave_ctrl_if #(.DATA_W(DATA_W), .FRAME_W(FRAME_W)) bus ();
`ifdef SPI_FRAME_ERR_EN
  logic frame_err;
`endif

  spi_slave_ctrl #(.DATA_W(DATA_W), .FRAME_W(FRAME_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus)
`ifdef SPI_FRAME_ERR_EN
    ,
    .frame_err (frame_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [9:0] word;
    bit         rd;
    logic [7:0] rbyte;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: RAM contents/pointers as the spec's opcode rules define them, plus read-address flag.
  bit         m_seen = 1'b0;
  logic [7:0] m_mem[256];
  logic [7:0] m_waddr = '0;
  logic [7:0] m_raddr = '0;
  int         m_err_exp = 0;
  int         err_seen = 0;

  int ram_lat = 2;
  bit mon_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one frame starting from IDLE; abort_at = bit index whose edge sees SS_n high (-1 none).
  task automatic send_frame(input logic [9:0] w, input int abort_at, input bit last_rise, input int tail);
    exp_t e;
    bit   routed_rd;
    int   t;
    bus.SS_n = 1'b0;
    bus.MOSI = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    for (int i = 9; i >= 0; i--) begin
      bus.MOSI = w[i];
      if (i == abort_at) begin
        bus.SS_n = 1'b1;
        m_err_exp++;
        @(posedge clk); #1;
        return;
      end
      if (i == 0 && last_rise) bus.SS_n = 1'b1;
      @(posedge clk); #1;
    end
    routed_rd = w[9] && m_seen;
    e.word  = w;
    e.rd    = routed_rd && (w[8] == 1'b1) && !last_rise;
    e.rbyte = m_mem[m_raddr];
    if (routed_rd && !last_rise && w[8] == 1'b0) m_err_exp++;
    if (w[9]) m_seen = !routed_rd;
    case (w[9:8])
      2'b00: m_waddr = w[7:0];
      2'b01: m_mem[m_waddr] = w[7:0];
      2'b10: m_raddr = w[7:0];
      default: ;
    endcase
    exp_q.push_back(e);
    t = e.rd ? 16 : tail;
    if (!last_rise) begin
      repeat (t) begin
        bus.MOSI = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
    end
    bus.SS_n = 1'b1;
    bus.MOSI = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input logic ss);
    rst = 1'b1;
    bus.SS_n = ss;
    repeat (2) begin
      @(posedge clk); #1;
      bus.MOSI = ~bus.MOSI;
    end
    rst = 1'b0;
    bus.SS_n = 1'b1;
    m_seen = 1'b0;
    @(posedge clk); #1;
  endtask

  // RAM responder: acts on every rx_valid word, answers opcode 11 with tx_valid after ram_lat cycles.
  initial begin : ram_model
    logic [7:0] ram_mem[256];
    logic [7:0] waddr, raddr;
    logic [9:0] w;
    int hold;
    waddr = '0;
    raddr = '0;
    for (int unsigned i = 0; i < 256; i++) ram_mem[i] = '0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'($urandom);
    forever begin
      @(posedge clk); #1;
      bus.tx_data = 8'($urandom);
      if (bus.rx_valid === 1'b1) begin
        w = bus.rx_data;
        case (w[9:8])
          2'b00: waddr = w[7:0];
          2'b01: ram_mem[waddr] = w[7:0];
          2'b10: raddr = w[7:0];
          default: begin
            repeat (ram_lat - 1) begin
              @(posedge clk); #1;
              bus.tx_data = 8'($urandom);
            end
            @(posedge clk); #1;
            bus.tx_valid = 1'b1;
            bus.tx_data  = ram_mem[raddr];
            hold = $urandom_range(1, 6);
            repeat (hold) begin @(posedge clk); #1; end
            bus.tx_valid = 1'b0;
            bus.tx_data  = 8'($urandom);
          end
        endcase
      end
    end
  end

  // Monitor: pops expected words on rx_valid, collects read bytes from MISO, requires MISO=0 otherwise.
  initial begin : monitor
    int bits_left;
    bit armed;
    logic [7:0] got, exp_byte;
    exp_t e;
    bits_left = 0;
    armed = 1'b0;
    got = '0;
    exp_byte = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bits_left > 0) begin
          got = {got[6:0], bus.MISO};
          bits_left--;
          if (bits_left == 0) check("miso_byte", 32'(got), 32'(exp_byte));
        end else begin
          check("miso_idle", 32'(bus.MISO), 32'd0);
        end
        if (bus.rx_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_valid_unexpected: got rx_data %0h expected no pulse at %0t", bus.rx_data, $time);
          end else begin
            e = exp_q.pop_front();
            check("rx_data", 32'(bus.rx_data), 32'(e.word));
            if (e.rd) begin
              armed = 1'b1;
              exp_byte = e.rbyte;
            end
          end
        end else if (bus.rx_valid !== 1'b0) begin
          check("rx_valid_known", 32'(bus.rx_valid), 32'd0);
        end
        if (armed) begin
          if (bus.tx_valid === 1'b1) begin
            armed = 1'b0;
            bits_left = 8;
          end else if (bus.SS_n) begin
            armed = 1'b0;
            check("tx_started", 32'd0, 32'd1);
          end
        end
`ifdef SPI_FRAME_ERR_EN
        if (frame_err === 1'b1) err_seen++;
`endif
      end
    end
  end

  initial begin : stimulus
    logic [9:0] w;
    int r, ab;
    bit lr;
    for (int unsigned i = 0; i < 256; i++) m_mem[i] = '0;
    bus.SS_n = 1'b0;
    bus.MOSI = 1'b0;
    rst = 1'b1;
    // Reset held two cycles with SS_n low and MOSI toggling.
    @(posedge clk); #1;
    bus.MOSI = 1'b1;
    mon_en = 1'b1;
    check("rst_rx_data", 32'(bus.rx_data), 32'd0);
    check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("rst_miso", 32'(bus.MISO), 32'd0);
    @(posedge clk); #1;
    bus.MOSI = 1'b0;
    rst = 1'b0;
    bus.SS_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_rx_data", 32'(bus.rx_data), 32'd0);
    check("post_rst_miso", 32'(bus.MISO), 32'd0);

    send_frame(10'h0A5, -1, 1'b0, 2);
    send_frame(10'h13C, -1, 1'b0, 2);
    send_frame(10'h3AA, -1, 1'b0, 2);   // routes READ_ADD: RAM answers but MISO must stay low
    do_reset(1'b0);

    send_frame(10'h007, -1, 1'b0, 1);
    send_frame(10'h1C3, -1, 1'b0, 1);
    send_frame(10'h207, -1, 1'b0, 1);
    send_frame(10'h300, -1, 1'b0, 0);

    send_frame(10'h15A, 4, 1'b0, 0);
    send_frame(10'h0A5, -1, 1'b0, 0);
    send_frame(10'h0FF, -1, 1'b0, 0);
    send_frame(10'h0FF, -1, 1'b0, 0);
    send_frame(10'h055, -1, 1'b1, 0);
    send_frame(10'h2C0, 9, 1'b0, 0);

    for (int n = 0; n < 200; n++) begin
      w  = 10'($urandom_range(0, 1023));
      r  = $urandom_range(0, 9);
      ab = (r == 0) ? $urandom_range(1, 9) : -1;
      lr = (r == 1);
      ram_lat = $urandom_range(1, 3);
      send_frame(w, ab, lr, $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
    end

    repeat (20) begin @(posedge clk); #1; end
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
`ifdef SPI_FRAME_ERR_EN
    check("frame_err_count", 32'(err_seen), 32'(m_err_exp));
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
